// File: rtl/recovery_controller_if.sv
// Bus bundle between the recovery controller and the pipeline/register files.
// The master side is the controller; the slave side is the core around it.
interface recovery_controller_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              ckpt_req;
   logic [DATA_W-1:0] ckpt_pc;
   logic              rollback_req;
   logic [DATA_W-1:0] rf_rd;
   logic [DATA_W-1:0] rr_rd;
   logic [ADDR_W-1:0] rf_a;
   logic              rf_we;
   logic [DATA_W-1:0] rf_wd;
   logic [ADDR_W-1:0] rr_a;
   logic              rr_we;
   logic [DATA_W-1:0] rr_wd;
   logic              stall;
   logic              ckpt_valid;
   logic              ckpt_done;
   logic              rollback_done;
   logic              pc_load;
   logic [DATA_W-1:0] pc_restore;
   logic              recover_fail;

   modport master (
      input  ckpt_req, ckpt_pc, rollback_req, rf_rd, rr_rd,
      output rf_a, rf_we, rf_wd, rr_a, rr_we, rr_wd, stall, ckpt_valid,
             ckpt_done, rollback_done, pc_load, pc_restore, recover_fail
   );

   modport slave (
      output ckpt_req, ckpt_pc, rollback_req, rf_rd, rr_rd,
      input  rf_a, rf_we, rf_wd, rr_a, rr_we, rr_wd, stall, ckpt_valid,
             ckpt_done, rollback_done, pc_load, pc_restore, recover_fail
   );
endinterface

// File: rtl/recovery_controller.sv
// Checkpoint/rollback sequencer: copies x1..x31 between the main and recovery
// register files one register per cycle while holding the pipeline stalled.
module recovery_controller #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int NUM_REGS = 32
) (
   input logic                   clk,
   input logic                   rst_in,
   recovery_controller_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      SAVE,
      RESTORE,
      DONE_S,
      DONE_R
   } state_t;

   localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

   state_t            state;
   logic [4:0]        idx;
   logic [DATA_W-1:0] saved_pc;
   logic              valid_q;
   logic              fail_q;
   logic [ADDR_W-1:0] idx_addr;

   assign idx_addr = ADDR_W'(idx);

   // A rollback arriving mid-save kills the half-written snapshot, so it is
   // reported as a failure rather than restoring from incomplete data.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         idx      <= 5'd1;
         saved_pc <= '0;
         valid_q  <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         fail_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.rollback_req) begin
                  if (valid_q) begin
                     state <= RESTORE;
                     idx   <= 5'd1;
                  end else begin
                     fail_q <= 1'b1;
                  end
               end else if (bus.ckpt_req) begin
                  state    <= SAVE;
                  idx      <= 5'd1;
                  saved_pc <= bus.ckpt_pc;
                  valid_q  <= 1'b0;
               end
            end
            SAVE: begin
               if (bus.rollback_req) begin
                  state  <= IDLE;
                  idx    <= 5'd1;
                  fail_q <= 1'b1;
               end else if (idx == LAST_IDX) begin
                  state <= DONE_S;
                  idx   <= 5'd1;
               end else begin
                  idx <= idx + 5'd1;
               end
            end
            RESTORE: begin
               if (idx == LAST_IDX) begin
                  state <= DONE_R;
                  idx   <= 5'd1;
               end else begin
                  idx <= idx + 5'd1;
               end
            end
            DONE_S: begin
               valid_q <= 1'b1;
               state   <= IDLE;
            end
            DONE_R: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               idx   <= 5'd1;
            end
         endcase
      end
   end

   // Register-file traffic is decoded straight from state and idx so each
   // write lands at the edge closing its copy cycle.
   always_comb begin
      bus.rf_a          = '0;
      bus.rf_we         = 1'b0;
      bus.rf_wd         = '0;
      bus.rr_a          = '0;
      bus.rr_we         = 1'b0;
      bus.rr_wd         = '0;
      bus.stall         = (state != IDLE);
      bus.ckpt_done     = (state == DONE_S);
      bus.rollback_done = (state == DONE_R);
      bus.pc_load       = (state == DONE_R);
      case (state)
         SAVE: begin
            bus.rf_a  = idx_addr;
            bus.rr_a  = idx_addr;
            bus.rr_we = 1'b1;
            bus.rr_wd = bus.rf_rd;
         end
         RESTORE: begin
            bus.rf_a  = idx_addr;
            bus.rr_a  = idx_addr;
            bus.rf_we = 1'b1;
            bus.rf_wd = bus.rr_rd;
         end
         default: ;
      endcase
   end

   assign bus.ckpt_valid   = valid_q;
   assign bus.pc_restore   = saved_pc;
   assign bus.recover_fail = fail_q;

endmodule

// File: tb/tb_recovery_controller.sv
// Self-checking bench for recovery_controller: behavioural register files plus
// a snapshot model (valid flag, saved PC, saved register image).
module tb_recovery_controller;

   logic clk = 1'b0;
   logic rst_in = 1'b0;

   recovery_controller_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   recovery_controller #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(32)) dut (
      .clk    (clk),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] main_rf [32];
   logic [31:0] rec_rf  [32];
   logic [31:0] rf_wr_q [$];
   logic [31:0] rr_wr_q [$];

   assign bus.rf_rd = main_rf[bus.rf_a[4:0]];
   assign bus.rr_rd = rec_rf[bus.rr_a[4:0]];

   // Register files commit at the rising edge; every write address is logged.
   always @(posedge clk) begin
      if (bus.rf_we) begin
         main_rf[bus.rf_a[4:0]] = bus.rf_wd;
         rf_wr_q.push_back(bus.rf_a);
      end
      if (bus.rr_we) begin
         rec_rf[bus.rr_a[4:0]] = bus.rr_wd;
         rr_wr_q.push_back(bus.rr_a);
      end
   end

   int checks = 0;
   int errors = 0;

   bit          model_valid = 1'b0;
   logic [31:0] model_pc    = '0;
   logic [31:0] model_snap [32];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts cycles after the accepting edge until the requested done pulse.
   task automatic wait_done(input bit rollback, output int n, output bit stall_ok);
      n = 0;
      stall_ok = 1'b1;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
         if (rollback ? (bus.rollback_done === 1'b1) : (bus.ckpt_done === 1'b1)) return;
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      bus.ckpt_req = 1'b0;
      bus.rollback_req = 1'b0;
      bus.ckpt_pc = '0;
      #12;
      checks++;
      if ({bus.stall, bus.rf_we, bus.rr_we, bus.ckpt_valid, bus.ckpt_done,
           bus.rollback_done, bus.pc_load, bus.recover_fail} !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b expected 00000000", {bus.stall, bus.rf_we,
                  bus.rr_we, bus.ckpt_valid, bus.ckpt_done, bus.rollback_done, bus.pc_load,
                  bus.recover_fail});
      end
      checks++;
      if (bus.rf_a !== 32'd0 || bus.rr_a !== 32'd0 || bus.pc_restore !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_buses: rf_a=%h rr_a=%h pc=%h expected all 0",
                  bus.rf_a, bus.rr_a, bus.pc_restore);
      end
      @(negedge clk);
      rst_in = 1'b1;
      model_valid = 1'b0;
      model_pc = '0;
      step();
   endtask

   task automatic test_checkpoint(input logic [31:0] pc, input bit pattern);
      int n;
      bit stall_ok;
      logic [31:0] snap [32];
      for (int i = 0; i < 32; i++) begin
         main_rf[i] = pattern ? 32'h1000 + 32'(i) : $urandom;
         snap[i] = main_rf[i];
      end
      rf_wr_q.delete();
      rr_wr_q.delete();
      bus.ckpt_pc = pc;
      bus.ckpt_req = 1'b1;
      step();
      bus.ckpt_req = 1'b0;
      bus.ckpt_pc = $urandom;
      wait_done(1'b0, n, stall_ok);
      checks++;
      if (n !== 32) begin
         errors++;
         $display("[TB] FAIL ckpt_latency: got %0d cycles expected 32", n);
      end
      checks++;
      if (!stall_ok) begin
         errors++;
         $display("[TB] FAIL ckpt_stall: stall dropped during save, expected high");
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.ckpt_valid !== 1'b1 || bus.stall !== 1'b0 || bus.ckpt_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ckpt_after: valid=%b stall=%b done=%b expected 1 0 0",
                  bus.ckpt_valid, bus.stall, bus.ckpt_done);
      end
      checks++;
      if (bus.pc_restore !== pc) begin
         errors++;
         $display("[TB] FAIL ckpt_pc: got %h expected %h", bus.pc_restore, pc);
      end
      checks++;
      if (rr_wr_q.size() !== 31 || rf_wr_q.size() !== 0) begin
         errors++;
         $display("[TB] FAIL ckpt_write_count: rr=%0d rf=%0d expected 31 0",
                  rr_wr_q.size(), rf_wr_q.size());
      end
      for (int i = 0; i < rr_wr_q.size() && i < 31; i++) begin
         checks++;
         if (rr_wr_q[i] !== 32'(i + 1)) begin
            errors++;
            $display("[TB] FAIL ckpt_addr_%0d: got %0d expected %0d", i, rr_wr_q[i], i + 1);
         end
      end
      for (int i = 1; i < 32; i++) begin
         checks++;
         if (rec_rf[i] !== snap[i]) begin
            errors++;
            $display("[TB] FAIL ckpt_x%0d: got %h expected %h", i, rec_rf[i], snap[i]);
         end
      end
      model_valid = 1'b1;
      model_pc = pc;
      for (int i = 0; i < 32; i++) model_snap[i] = snap[i];
   endtask

   task automatic test_rollback(input bit dead);
      int n;
      bit stall_ok;
      logic [31:0] x0_before;
      for (int i = 1; i < 32; i++) main_rf[i] = dead ? 32'hDEAD : $urandom;
      x0_before = main_rf[0];
      rf_wr_q.delete();
      rr_wr_q.delete();
      bus.rollback_req = 1'b1;
      step();
      bus.rollback_req = 1'b0;
      if (model_valid) begin
         wait_done(1'b1, n, stall_ok);
         checks++;
         if (n !== 32 || bus.pc_load !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rb_latency: got %0d cycles pc_load=%b expected 32 1", n, bus.pc_load);
         end
         checks++;
         if (!stall_ok) begin
            errors++;
            $display("[TB] FAIL rb_stall: stall dropped during restore, expected high");
         end
         checks++;
         if (bus.pc_restore !== model_pc) begin
            errors++;
            $display("[TB] FAIL rb_pc: got %h expected %h", bus.pc_restore, model_pc);
         end
         step();
         @(negedge clk);
         checks++;
         if ({bus.rollback_done, bus.pc_load, bus.stall, bus.ckpt_valid} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rb_after: done,pc_load,stall,valid=%b expected 0001",
                     {bus.rollback_done, bus.pc_load, bus.stall, bus.ckpt_valid});
         end
         checks++;
         if (rf_wr_q.size() !== 31 || rr_wr_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL rb_write_count: rf=%0d rr=%0d expected 31 0",
                     rf_wr_q.size(), rr_wr_q.size());
         end
         checks++;
         if (main_rf[0] !== x0_before) begin
            errors++;
            $display("[TB] FAIL rb_x0: got %h expected %h", main_rf[0], x0_before);
         end
         for (int i = 1; i < 32; i++) begin
            checks++;
            if (main_rf[i] !== model_snap[i]) begin
               errors++;
               $display("[TB] FAIL rb_x%0d: got %h expected %h", i, main_rf[i], model_snap[i]);
            end
         end
      end else begin
         @(negedge clk);
         checks++;
         if (bus.recover_fail !== 1'b1 || bus.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rb_invalid_fail: fail=%b stall=%b expected 1 0",
                     bus.recover_fail, bus.stall);
         end
         step();
         @(negedge clk);
         checks++;
         if (bus.recover_fail !== 1'b0 || bus.stall !== 1'b0 || bus.ckpt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rb_invalid_after: fail=%b stall=%b valid=%b expected 0 0 0",
                     bus.recover_fail, bus.stall, bus.ckpt_valid);
         end
         checks++;
         if (rf_wr_q.size() !== 0 || rr_wr_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL rb_invalid_writes: rf=%0d rr=%0d expected 0 0",
                     rf_wr_q.size(), rr_wr_q.size());
         end
      end
   endtask

   task automatic test_abort();
      logic [31:0] snap [32];
      for (int i = 0; i < 32; i++) begin
         main_rf[i] = $urandom;
         snap[i] = main_rf[i];
      end
      rf_wr_q.delete();
      rr_wr_q.delete();
      bus.ckpt_pc = $urandom;
      bus.ckpt_req = 1'b1;
      step();
      bus.ckpt_req = 1'b0;
      repeat (8) step();
      bus.rollback_req = 1'b1;
      step();
      bus.rollback_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.recover_fail, bus.stall, bus.ckpt_valid} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL abort_flags: fail,stall,valid=%b expected 100",
                  {bus.recover_fail, bus.stall, bus.ckpt_valid});
      end
      checks++;
      if (rr_wr_q.size() !== 9 || rf_wr_q.size() !== 0) begin
         errors++;
         $display("[TB] FAIL abort_writes: rr=%0d rf=%0d expected 9 0", rr_wr_q.size(), rf_wr_q.size());
      end
      for (int i = 1; i <= 9; i++) begin
         checks++;
         if (rec_rf[i] !== snap[i]) begin
            errors++;
            $display("[TB] FAIL abort_x%0d: got %h expected %h", i, rec_rf[i], snap[i]);
         end
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.recover_fail !== 1'b0 || rr_wr_q.size() !== 9) begin
         errors++;
         $display("[TB] FAIL abort_after: fail=%b rr=%0d expected 0 9", bus.recover_fail, rr_wr_q.size());
      end
      model_valid = 1'b0;
   endtask

   task automatic test_simultaneous();
      int n;
      bit stall_ok;
      for (int i = 1; i < 32; i++) main_rf[i] = $urandom;
      rf_wr_q.delete();
      rr_wr_q.delete();
      bus.ckpt_pc = ~model_pc;
      bus.ckpt_req = 1'b1;
      bus.rollback_req = 1'b1;
      step();
      bus.ckpt_req = 1'b0;
      bus.rollback_req = 1'b0;
      wait_done(1'b1, n, stall_ok);
      checks++;
      if (n !== 32 || !stall_ok) begin
         errors++;
         $display("[TB] FAIL simul_restore: got %0d cycles stall_ok=%b expected 32 1", n, stall_ok);
      end
      checks++;
      if (bus.pc_restore !== model_pc) begin
         errors++;
         $display("[TB] FAIL simul_pc: got %h expected %h", bus.pc_restore, model_pc);
      end
      step();
      @(negedge clk);
      checks++;
      if (rr_wr_q.size() !== 0 || rf_wr_q.size() !== 31 || bus.ckpt_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL simul_writes: rr=%0d rf=%0d valid=%b expected 0 31 1",
                  rr_wr_q.size(), rf_wr_q.size(), bus.ckpt_valid);
      end
      for (int i = 1; i < 32; i++) begin
         checks++;
         if (main_rf[i] !== model_snap[i]) begin
            errors++;
            $display("[TB] FAIL simul_x%0d: got %h expected %h", i, main_rf[i], model_snap[i]);
         end
      end
   endtask

   task automatic test_ignored_requests();
      int n;
      bit stall_ok;
      for (int i = 1; i < 32; i++) main_rf[i] = $urandom;
      rf_wr_q.delete();
      rr_wr_q.delete();
      bus.rollback_req = 1'b1;
      step();
      bus.rollback_req = 1'b0;
      repeat (4) step();
      bus.ckpt_pc = ~model_pc;
      bus.ckpt_req = 1'b1;
      step();
      bus.ckpt_req = 1'b0;
      bus.rollback_req = 1'b1;
      step();
      bus.rollback_req = 1'b0;
      wait_done(1'b1, n, stall_ok);
      checks++;
      if (n + 6 !== 32) begin
         errors++;
         $display("[TB] FAIL ignored_latency: got %0d cycles expected 32", n + 6);
      end
      checks++;
      if (bus.pc_restore !== model_pc || rr_wr_q.size() !== 0 || rf_wr_q.size() !== 31) begin
         errors++;
         $display("[TB] FAIL ignored_effect: pc=%h rr=%0d rf=%0d expected %h 0 31",
                  bus.pc_restore, rr_wr_q.size(), rf_wr_q.size(), model_pc);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b0 || bus.ckpt_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ignored_after: stall=%b valid=%b expected 0 1", bus.stall, bus.ckpt_valid);
      end
   endtask

   task automatic test_reset_mid_save();
      for (int i = 0; i < 32; i++) main_rf[i] = $urandom;
      bus.ckpt_pc = $urandom;
      bus.ckpt_req = 1'b1;
      step();
      bus.ckpt_req = 1'b0;
      repeat (5) step();
      #2;
      rst_in = 1'b0;
      #1;
      checks++;
      if ({bus.stall, bus.rr_we, bus.rf_we, bus.ckpt_valid, bus.ckpt_done, bus.recover_fail} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL midreset_flags: stall,rr_we,rf_we,valid,done,fail=%b expected 000000",
                  {bus.stall, bus.rr_we, bus.rf_we, bus.ckpt_valid, bus.ckpt_done, bus.recover_fail});
      end
      checks++;
      if (bus.rr_a !== 32'd0 || bus.pc_restore !== 32'd0) begin
         errors++;
         $display("[TB] FAIL midreset_buses: rr_a=%h pc=%h expected 0 0", bus.rr_a, bus.pc_restore);
      end
      @(negedge clk);
      rst_in = 1'b1;
      model_valid = 1'b0;
      model_pc = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_rollback(1'b0);
      test_checkpoint(32'h80, 1'b1);
      test_rollback(1'b1);
      test_rollback(1'b1);
      test_abort();
      test_rollback(1'b0);
      test_checkpoint($urandom, 1'b0);
      test_simultaneous();
      test_ignored_requests();
      test_reset_mid_save();
      test_rollback(1'b0);
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(0, 1) == 1) test_checkpoint($urandom, 1'b0);
         else test_rollback(1'($urandom_range(0, 1)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
